// File: rtl/acondicionador_entradas.sv
// Input conditioning for the I and S pushbuttons/switches.
// Each channel synchronizes its raw input with two flops. A four-state FSM then
// debounces the synchronized level, and the block produces the stable level, a
// one-cycle rising-edge pulse per channel and a shared one-cycle update pulse.
module acondicionador_entradas #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic I_raw,
  input  logic S_raw,
  output logic I,
  output logic S,
  output logic I_rise,
  output logic S_rise,
  output logic upd
);

  typedef enum logic [1:0] {ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW} state_t;

  // Last count value of a qualifying run; the counter never goes past it.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE - 1);

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic [1:0] chg;
  logic       upd_q;

  assign raw = {S_raw, I_raw};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic             sync1_q;
    logic             sync_q;
    state_t           st_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;
    logic             rise_q;
    logic             done;

    assign done = (cnt_q == CntMax);

    // Two-flop synchronizer; only sync_q is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync_q  <= 1'b0;
      end else begin
        sync1_q <= raw[c];
        sync_q  <= sync1_q;
      end
    end

    // Debounce FSM with registered level and rise pulse.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q   <= ST_LOW;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        unique case (st_q)
          ST_LOW: begin
            cnt_q <= '0;
            if (sync_q) st_q <= CHK_HIGH;
          end
          CHK_HIGH: begin
            if (!sync_q) begin
              st_q  <= ST_LOW;
              cnt_q <= '0;
            end else if (done) begin
              st_q   <= ST_HIGH;
              cnt_q  <= '0;
              lvl_q  <= 1'b1;
              rise_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_HIGH: begin
            cnt_q <= '0;
            if (!sync_q) st_q <= CHK_LOW;
          end
          CHK_LOW: begin
            if (sync_q) begin
              st_q  <= ST_HIGH;
              cnt_q <= '0;
            end else if (done) begin
              st_q  <= ST_LOW;
              cnt_q <= '0;
              lvl_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            st_q  <= ST_LOW;
            cnt_q <= '0;
          end
        endcase
      end
    end

    // The level flips on this edge when a check state completes its run.
    assign chg[c]  = done && (((st_q == CHK_HIGH) && sync_q) || ((st_q == CHK_LOW) && !sync_q));
    assign lvl[c]  = lvl_q;
    assign rise[c] = rise_q;
  end

  // One update pulse however many channels change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_q <= 1'b0;
    else        upd_q <= |chg;
  end

  assign I      = lvl[0];
  assign S      = lvl[1];
  assign I_rise = rise[0];
  assign S_rise = rise[1];
  assign upd    = upd_q;

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Bench for acondicionador_entradas: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a behavioural model.
// The model treats each channel as a level that flips once the synchronized input
// has disagreed with it for DEBOUNCE+1 consecutive samples.
module tb_acondicionador_entradas;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic I_raw = 1'b0;
  logic S_raw = 1'b0;
  logic I, S, I_rise, S_rise, upd;

  int checks = 0;
  int errors = 0;

  // Model state: synchronizer pipeline, disagreement run length, level.
  logic m_s1 [2];
  logic m_xs [2];
  int   m_run [2];
  logic m_lvl [2];
  logic m_rise [2];
  logic m_upd;

  acondicionador_entradas #(.DEBOUNCE(D), .CNT_W(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .I_raw  (I_raw),
    .S_raw  (S_raw),
    .I      (I),
    .S      (S),
    .I_rise (I_rise),
    .S_rise (S_rise),
    .upd    (upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1'b0; m_xs[c] = 1'b0; m_run[c] = 0; m_lvl[c] = 1'b0; m_rise[c] = 1'b0;
    end
    m_upd = 1'b0;
  endtask

  // Advance the model by one clock edge using the raw values present before it.
  task automatic model_step(input logic ri, input logic rs);
    logic r [2];
    logic any;
    r[0] = ri; r[1] = rs;
    any = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_rise[c] = 1'b0;
      if (m_xs[c] != m_lvl[c]) m_run[c]++;
      else                     m_run[c] = 0;
      if (m_run[c] == D + 1) begin
        m_lvl[c]  = ~m_lvl[c];
        m_rise[c] = m_lvl[c];
        m_run[c]  = 0;
        any = 1'b1;
      end
      m_xs[c] = m_s1[c];
      m_s1[c] = r[c];
    end
    m_upd = any;
  endtask

  // Drive raw inputs, take one clock edge, land 1 time unit after it.
  task automatic tick(input logic ri, input logic rs);
    I_raw = ri;
    S_raw = rs;
    @(posedge clk);
    if (rst_n) model_step(ri, rs);
    #1;
  endtask

  // Asynchronous reset between edges, released on the following falling edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_I", I, 1'b0);
    check("rst_async_S", S, 1'b0);
    check("rst_async_upd", upd, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_I", I, m_lvl[0]);
    check("cmp_S", S, m_lvl[1]);
    check("cmp_I_rise", I_rise, m_rise[0]);
    check("cmp_S_rise", S_rise, m_rise[1]);
    check("cmp_upd", upd, m_upd);
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_I", I, 1'b0);
    check("reset_S", S, 1'b0);
    check("reset_I_rise", I_rise, 1'b0);
    check("reset_S_rise", S_rise, 1'b0);
    check("reset_upd", upd, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);

    // Clean press: output rises on edge 7.
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b0);
      if (k == 6) check("press_I_e6", I, 1'b0);
      if (k == 7) begin
        check("press_I_e7", I, 1'b1);
        check("press_rise_e7", I_rise, 1'b1);
        check("press_upd_e7", upd, 1'b1);
      end
      if (k == 8) begin
        check("press_rise_e8", I_rise, 1'b0);
        check("press_upd_e8", upd, 1'b0);
      end
      check("press_S", S, 1'b0);
    end

    // Release: output falls on edge 7 with no rise pulse.
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b0);
      if (k == 6) check("rel_I_e6", I, 1'b1);
      if (k == 7) begin
        check("rel_I_e7", I, 1'b0);
        check("rel_upd_e7", upd, 1'b1);
      end
      if (k == 8) check("rel_upd_e8", upd, 1'b0);
      check("rel_rise", I_rise, 1'b0);
    end

    // Glitch on S: three cycles high is too short.
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, (k <= 3));
      check("glitch_S", S, 1'b0);
      check("glitch_S_rise", S_rise, 1'b0);
      check("glitch_upd", upd, 1'b0);
    end

    // Bounce 1,0,1,0 then held: rise 6 edges after the first held sample (tick 5).
    for (int k = 1; k <= 12; k++) begin
      tick((k >= 5) ? 1'b1 : ((k % 2) == 1), 1'b0);
      if (k == 10) check("bounce_I_e10", I, 1'b0);
      if (k == 11) check("bounce_I_e11", I, 1'b1);
    end
    for (int k = 0; k < 9; k++) tick(1'b0, 1'b0);

    // Simultaneous press: same edge, both rise pulses, single upd.
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b1);
      if (k == 7) begin
        check("sim_I", I, 1'b1);
        check("sim_S", S, 1'b1);
        check("sim_I_rise", I_rise, 1'b1);
        check("sim_S_rise", S_rise, 1'b1);
        check("sim_upd_e7", upd, 1'b1);
      end
      if (k == 8) check("sim_upd_e8", upd, 1'b0);
    end

    // S released, then re-pressed and reset while S is still being checked.
    for (int k = 0; k < 8; k++) tick(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b1);
    mid_reset();
    for (int k = 1; k <= 7; k++) begin
      tick(1'b1, 1'b1);
      if (k < 7) begin
        check("rstrel_I", I, 1'b0);
        check("rstrel_upd", upd, 1'b0);
      end else begin
        check("rstrel_I_e7", I, 1'b1);
        check("rstrel_S_e7", S, 1'b1);
        check("rstrel_upd_e7", upd, 1'b1);
      end
    end

    // Randomized: sticky levels with occasional toggles and rare resets.
    begin
      logic ri, rs;
      ri = 1'b1; rs = 1'b1;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 5) == 0) ri = ~ri;
        if ($urandom_range(0, 5) == 0) rs = ~rs;
        if ($urandom_range(0, 399) == 0) mid_reset();
        tick(ri, rs);
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
